riscv_lsu: RTL and testbench

Load/store unit between the RISC-V datapath and the word-only synchronous data memory.
- Accepts byte/halfword/word load and store requests over a valid/ready handshake.
- Drives the memory's word address, write-enable and write data, and consumes the memory's 1-cycle-latency read data.
- Performs lane extraction with sign/zero extension for loads.
- Implements sb/sh as read-modify-write, because the memory only writes whole words.
- Flags misaligned, out-of-range or illegal accesses without touching memory.

---
 rtl/riscv_lsu_pkg.sv | 41 ++++
 rtl/riscv_lsu_align.sv | 34 +++
 rtl/riscv_lsu.sv | 147 ++++++++++++++
 tb/tb_riscv_lsu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared encodings and the access-legality check for the RISC-V load/store unit.
package riscv_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_MERGE   = 3'd3,
        S_WRITE   = 3'd4,
        S_RESP    = 3'd5
    } lsu_state_t;

    // 1 when the access must fault instead of reaching memory.
    function automatic logic lsu_access_err(
        input logic        write,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned addr_bits
    );
        logic bad_f3;
        logic bad_align;
        logic bad_range;
        case (funct3)
            LSU_B, LSU_H, LSU_W: bad_f3 = 1'b0;
            LSU_BU, LSU_HU:      bad_f3 = write;
            default:             bad_f3 = 1'b1;
        endcase
        bad_align = (((funct3 == LSU_H) || (funct3 == LSU_HU)) && addr[0])
                  || ((funct3 == LSU_W) && (addr[1:0] != 2'b00));
        bad_range = (addr >> addr_bits) != (base >> addr_bits);
        return bad_f3 || bad_align || bad_range;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: load extract/extend and sb/sh read-modify-write merge.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_shamt;
    logic [31:0] w_lane;
    logic [31:0] w_mask;

    assign w_shamt = {i_addr_lo, 3'b000};
    assign w_lane  = i_word >> w_shamt;
    assign w_mask  = (i_funct3 == LSU_H) ? 32'h0000_FFFF : 32'h0000_00FF;

    always_comb begin
        o_load_data = w_lane;
        case (i_funct3)
            LSU_B:   o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            LSU_H:   o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            LSU_BU:  o_load_data = {24'h000000, w_lane[7:0]};
            LSU_HU:  o_load_data = {16'h0000, w_lane[15:0]};
            default: o_load_data = w_lane;
        endcase
    end

    assign o_merge_data = (i_word & ~(w_mask << w_shamt)) | ((i_wdata & w_mask) << w_shamt);

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit fronting a word-only, 1-cycle-latency synchronous data memory.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned DATA_BRAMS         = 2,
    parameter logic [31:0] DATA_START_ADDRESS = 32'h0080_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DATA_ADDR_BITS = 11 + DATA_BRAMS;

    lsu_state_t  r_state,      w_state_nx;
    logic        r_write,      w_write_nx;
    logic [2:0]  r_funct3,     w_funct3_nx;
    logic [1:0]  r_addr_lo,    w_addr_lo_nx;
    logic [31:0] r_wdata,      w_wdata_nx;
    logic        r_req_ready,  w_req_ready_nx;
    logic        r_resp_valid, w_resp_valid_nx;
    logic [31:0] r_resp_rdata, w_resp_rdata_nx;
    logic        r_resp_err,   w_resp_err_nx;
    logic [31:0] r_mem_addr,   w_mem_addr_nx;
    logic        r_mem_we,     w_mem_we_nx;
    logic [31:0] r_mem_wdata,  w_mem_wdata_nx;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    riscv_lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr_lo),
        .i_word       (mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_wdata      <= 32'h0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 32'h0;
        end else begin
            r_state      <= w_state_nx;
            r_write      <= w_write_nx;
            r_funct3     <= w_funct3_nx;
            r_addr_lo    <= w_addr_lo_nx;
            r_wdata      <= w_wdata_nx;
            r_req_ready  <= w_req_ready_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_rdata <= w_resp_rdata_nx;
            r_resp_err   <= w_resp_err_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_we     <= w_mem_we_nx;
            r_mem_wdata  <= w_mem_wdata_nx;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        w_state_nx      = r_state;
        w_write_nx      = r_write;
        w_funct3_nx     = r_funct3;
        w_addr_lo_nx    = r_addr_lo;
        w_wdata_nx      = r_wdata;
        w_resp_rdata_nx = r_resp_rdata;
        w_resp_err_nx   = r_resp_err;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_we_nx     = 1'b0;
        w_mem_wdata_nx  = r_mem_wdata;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_write_nx      = req_write;
                    w_funct3_nx     = req_funct3;
                    w_addr_lo_nx    = req_addr[1:0];
                    w_wdata_nx      = req_wdata;
                    w_resp_rdata_nx = 32'h0;
                    w_resp_err_nx   = lsu_access_err(req_write, req_funct3, req_addr,
                                                     DATA_START_ADDRESS, DATA_ADDR_BITS);
                    if (w_resp_err_nx) begin
                        w_state_nx = S_RESP;
                    end else begin
                        w_state_nx    = S_ISSUE;
                        w_mem_addr_nx = {req_addr[31:2], 2'b00};
                        if (req_write && (req_funct3 == LSU_W)) begin
                            w_mem_we_nx    = 1'b1;
                            w_mem_wdata_nx = req_wdata;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (!r_write)                w_state_nx = S_CAPTURE;
                else if (r_funct3 == LSU_W)  w_state_nx = S_RESP;
                else                         w_state_nx = S_MERGE;
            end
            S_CAPTURE: begin
                w_resp_rdata_nx = w_load_data;
                w_state_nx      = S_RESP;
            end
            S_MERGE: begin
                w_mem_wdata_nx = w_merge_data;
                w_mem_we_nx    = 1'b1;
                w_state_nx     = S_WRITE;
            end
            S_WRITE:  w_state_nx = S_RESP;
            S_RESP:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase

        w_req_ready_nx  = (w_state_nx == S_IDLE);
        w_resp_valid_nx = (w_state_nx == S_RESP);
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a 1-cycle-latency word memory model.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        mem_init = 1'b1;
    logic [31:0] mem [0:2047];

    int n_checks = 0;
    int n_errors = 0;

    logic        mon_en = 1'b0;
    int          mon_cnt = 0;
    logic [31:0] mon_rd [0:15];

    riscv_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
            mem[1]     <= 32'h8899AABB;
            mem[11'h7FF] <= 32'h80000000;
        end else if (mem_we) begin
            mem[mem_addr[12:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[12:2]];
    end

    always @(negedge clk) begin
        if (mon_en && resp_valid) begin
            if (mon_cnt < 16) mon_rd[mon_cnt] <= resp_rdata;
            mon_cnt <= mon_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_we, input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata);
        int          lat = 0;
        int          we_n = 0;
        logic [31:0] rd = 32'h0;
        logic        er = 1'b0;
        logic [31:0] ma = 32'h0;
        logic [31:0] mw = 32'h0;
        logic [31:0] iss_addr = 32'h0;
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                iss_addr  = mem_addr;
            end
            if (resp_valid && lat == 0) begin
                lat = k; rd = resp_rdata; er = resp_err;
            end
            if (mem_we) begin
                we_n++; ma = mem_addr; mw = mem_wdata;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_we_cnt"}, 32'(we_n), 32'(exp_we));
        if (!exp_err) check({tag, "_mem_addr"}, (exp_we != 0) ? ma : iss_addr, exp_maddr);
        if (exp_we != 0) check({tag, "_mem_wdata"}, mw, exp_mwdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s_addr [0:5];
        logic        s_wr   [0:5];
        logic [31:0] s_wd   [0:5];
        logic [31:0] s_exp  [0:5];
        int          t;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b1; mem_init = 1'b0;

        // Loads and extension
        do_req("lb",     1'b0, 3'b000, 32'h00800005, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 0, 32'h00800004, 32'h0);
        do_req("lbu",    1'b0, 3'b100, 32'h00800005, 32'h0, 3, 32'h000000AA, 1'b0, 0, 32'h00800004, 32'h0);
        do_req("lhu",    1'b0, 3'b101, 32'h00800006, 32'h0, 3, 32'h00008899, 1'b0, 0, 32'h00800004, 32'h0);
        do_req("lh",     1'b0, 3'b001, 32'h00800006, 32'h0, 3, 32'hFFFF8899, 1'b0, 0, 32'h00800004, 32'h0);
        do_req("lb_top", 1'b0, 3'b000, 32'h00801FFF, 32'h0, 3, 32'hFFFFFF80, 1'b0, 0, 32'h00801FFC, 32'h0);

        // Sub-word stores via read-modify-write
        do_req("sb",     1'b1, 3'b000, 32'h00800006, 32'h12345678, 4, 32'h0, 1'b0, 1, 32'h00800004, 32'h8878AABB);
        check("sb_mem", mem[1], 32'h8878AABB);
        do_req("lw_sb",  1'b0, 3'b010, 32'h00800004, 32'h0, 3, 32'h8878AABB, 1'b0, 0, 32'h00800004, 32'h0);
        do_req("sh",     1'b1, 3'b001, 32'h00800006, 32'h0000CAFE, 4, 32'h0, 1'b0, 1, 32'h00800004, 32'hCAFEAABB);
        do_req("lw_sh",  1'b0, 3'b010, 32'h00800004, 32'h0, 3, 32'hCAFEAABB, 1'b0, 0, 32'h00800004, 32'h0);

        do_req("sw",     1'b1, 3'b010, 32'h00800008, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'h00800008, 32'hDEADBEEF);
        check("sw_mem", mem[2], 32'hDEADBEEF);

        // Faulting accesses
        do_req("e_lh_mis", 1'b0, 3'b001, 32'h00800005, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
        do_req("e_sw_mis", 1'b1, 3'b010, 32'h00800002, 32'h55, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
        do_req("e_range",  1'b0, 3'b010, 32'h00400000, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
        do_req("e_f3_011", 1'b0, 3'b011, 32'h00800004, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
        do_req("e_sbu",    1'b1, 3'b100, 32'h00800004, 32'h77, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
        do_req("e_above",  1'b0, 3'b000, 32'h00802000, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
        check("err_mem_unchanged", mem[1], 32'hCAFEAABB);

        // Reset during MERGE of an sb
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h00800008; req_wdata = 32'h00000011;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_req_ready", 32'(req_ready), 32'h1);
        check("mrst_resp_valid", 32'(resp_valid), 32'h0);
        check("mrst_mem_we", 32'(mem_we), 32'h0);
        check("mrst_mem_addr", mem_addr, 32'h0);
        check("mrst_mem_wdata", mem_wdata, 32'h0);
        check("mrst_resp_rdata", resp_rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_mem", mem[2], 32'hDEADBEEF);
        check("mrst_ready_after", 32'(req_ready), 32'h1);
        check("mrst_mem_we_after", 32'(mem_we), 32'h0);

        // Back-to-back alternating sw/lw with req_valid held high
        s_wr[0] = 1'b1; s_addr[0] = 32'h00800010; s_wd[0] = 32'hA0A0A0A0; s_exp[0] = 32'h0;
        s_wr[1] = 1'b0; s_addr[1] = 32'h00800010; s_wd[1] = 32'h0;        s_exp[1] = 32'hA0A0A0A0;
        s_wr[2] = 1'b1; s_addr[2] = 32'h00800014; s_wd[2] = 32'hA1A1A1A1; s_exp[2] = 32'h0;
        s_wr[3] = 1'b0; s_addr[3] = 32'h00800014; s_wd[3] = 32'h0;        s_exp[3] = 32'hA1A1A1A1;
        s_wr[4] = 1'b1; s_addr[4] = 32'h00800010; s_wd[4] = 32'hA2A2A2A2; s_exp[4] = 32'h0;
        s_wr[5] = 1'b0; s_addr[5] = 32'h00800010; s_wd[5] = 32'h0;        s_exp[5] = 32'hA2A2A2A2;
        mon_en = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_write = s_wr[i]; req_funct3 = 3'b010; req_addr = s_addr[i]; req_wdata = s_wd[i];
            t = 0;
            while (!req_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) check("stream_accept_timeout", 32'(t), 32'h0);
            @(posedge clk);
            @(negedge clk);
            if (i == 5) req_valid = 1'b0;
            check("stream_busy", 32'(req_ready), 32'h0);
        end
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        check("stream_resp_cnt", 32'(mon_cnt), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("stream_rdata%0d", i), mon_rd[i], s_exp[i]);
        check("stream_mem4", mem[4], 32'hA2A2A2A2);
        check("stream_mem5", mem[5], 32'hA1A1A1A1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
